// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC processing element.
package mac_pkg;

  typedef enum logic [1:0] {IDLE, ACC, DONE} pe_state_e;

  function automatic logic signed [63:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Signed add overflow: equal addend signs, different sum sign.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/mac_mult_reg.sv
// Stage 1 of the MAC PE: registered signed multiply with valid/last pipelining.
module mac_mult_reg #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic              last,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [ACC_W-1:0]  p_q,
  output logic              p_vld,
  output logic              p_last
);

  logic signed [2*DATA_W-1:0] a_x;
  logic signed [2*DATA_W-1:0] b_x;
  logic signed [2*DATA_W-1:0] prod;

  always_comb begin
    a_x  = (2*DATA_W)'($signed(A));
    b_x  = (2*DATA_W)'($signed(B));
    prod = a_x * b_x;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_q    <= '0;
      p_vld  <= 1'b0;
      p_last <= 1'b0;
    end else begin
      p_vld  <= valid;
      p_last <= valid & last;
      if (valid) p_q <= ACC_W'(prod);
    end
  end

endmodule

// File: rtl/mac_pe.sv
// Signed MAC processing element: accumulator, frame FSM, sticky overflow, operand forwarding.
// Define MAC_PE_SATURATE_EN to clamp y on overflow instead of wrapping.
module mac_pe
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              last,
  input  logic              clear,
  output logic [DATA_W-1:0] A_out,
  output logic [DATA_W-1:0] B_out,
  output logic              valid_out,
  output logic [ACC_W-1:0]  y,
  output logic              overflow,
  output logic              done
);

  logic [ACC_W-1:0] p_q;
  logic             p_vld;
  logic             p_last;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] y_nxt;
  logic             ovf;
  pe_state_e        state, state_nxt;

  mac_mult_reg #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mult (
    .clk    (clk),
    .reset  (reset),
    .valid  (valid),
    .last   (last),
    .A      (A),
    .B      (B),
    .p_q    (p_q),
    .p_vld  (p_vld),
    .p_last (p_last)
  );

`ifdef MAC_PE_SATURATE_EN
  localparam logic signed [63:0] SAT_MAX64 = sat_max(ACC_W);
  localparam logic signed [63:0] SAT_MIN64 = sat_min(ACC_W);
  localparam logic [ACC_W-1:0]   Y_MAX     = SAT_MAX64[ACC_W-1:0];
  localparam logic [ACC_W-1:0]   Y_MIN     = SAT_MIN64[ACC_W-1:0];
`endif

  // Only ACC continues a frame; IDLE and DONE both start from zero.
  always_comb begin
    base = (state == ACC) ? y : '0;
    sum  = base + p_q;
    ovf  = add_ovf(base[ACC_W-1], p_q[ACC_W-1], sum[ACC_W-1]);
`ifdef MAC_PE_SATURATE_EN
    y_nxt = ovf ? (p_q[ACC_W-1] ? Y_MIN : Y_MAX) : sum;
`else
    y_nxt = sum;
`endif
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (p_vld) state_nxt = p_last ? DONE : ACC;
        ACC:     if (p_vld && p_last) state_nxt = DONE;
        DONE:    state_nxt = p_vld ? (p_last ? DONE : ACC) : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb done = (state == DONE);

  // clear wins over a pending product so it never reaches the accumulator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y        <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      y        <= '0;
      overflow <= 1'b0;
    end else if (p_vld) begin
      y        <= y_nxt;
      overflow <= (state == ACC) ? (overflow | ovf) : ovf;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      A_out     <= '0;
      B_out     <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid;
      if (valid) begin
        A_out <= A;
        B_out <= B;
      end
    end
  end

endmodule

// File: tb/tb_mac_pe.sv
// Scoreboard bench for mac_pe: stimulus queues expected dot products, a monitor checks them on done.
module tb_mac_pe;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              valid = 1'b0;
  logic [DATA_W-1:0] A = '0;
  logic [DATA_W-1:0] B = '0;
  logic              last = 1'b0;
  logic              clear = 1'b0;
  logic [DATA_W-1:0] A_out;
  logic [DATA_W-1:0] B_out;
  logic              valid_out;
  logic [ACC_W-1:0]  y;
  logic              overflow;
  logic              done;

  mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid),
    .A         (A),
    .B         (B),
    .last      (last),
    .clear     (clear),
    .A_out     (A_out),
    .B_out     (B_out),
    .valid_out (valid_out),
    .y         (y),
    .overflow  (overflow),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   yv;
    logic ovf;
    int   cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   drv_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int a, input int b, input logic v, input logic l, input logic c);
    @(negedge clk);
    A       = a[DATA_W-1:0];
    B       = b[DATA_W-1:0];
    valid   = v;
    last    = l;
    clear   = c;
    drv_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Called right after driving the last pair: done is due two edges later.
  task automatic expect_done(input int yv, input logic ovf);
    exp_t e;
    e.yv  = yv;
    e.ovf = ovf;
    e.cyc = drv_cyc + 2;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_y", $signed(y), e.yv);
        chk("done_ovf", int'(overflow), int'(e.ovf));
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout, expected completion");
    summary();
    $finish;
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_y", int'(y), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid_out", int'(valid_out), 0);
    chk("rst_A_out", int'(A_out), 0);
    chk("rst_B_out", int'(B_out), 0);

    // 30*40 + 10*8
    drive(30, 40, 1'b1, 1'b0, 1'b0);
    drive(10, 8, 1'b1, 1'b1, 1'b0);
    expect_done(1280, 1'b0);
    idle(4);

    // 100*-2 + 11*-11
    drive(100, -2, 1'b1, 1'b0, 1'b0);
    drive(11, -11, 1'b1, 1'b1, 1'b0);
    expect_done(-321, 1'b0);
    idle(4);

    // Three 127*127 terms overflow a 16-bit accumulator
    drive(127, 127, 1'b1, 1'b0, 1'b0);
    drive(127, 127, 1'b1, 1'b0, 1'b0);
    drive(127, 127, 1'b1, 1'b1, 1'b0);
    chk("acc_first", $signed(y), 16129);
`ifdef MAC_PE_SATURATE_EN
    expect_done(32767, 1'b1);
`else
    expect_done(-17149, 1'b1);
`endif
    idle(1);
    chk("acc_second", $signed(y), 32258);
    idle(3);
    chk("ovf_sticky", int'(overflow), 1);
    drive(1, 1, 1'b1, 1'b1, 1'b0);
    expect_done(1, 1'b0);
    idle(4);

    // Frame restart straight out of DONE
    drive(2, 2, 1'b1, 1'b1, 1'b0);
    expect_done(4, 1'b0);
    drive(3, 3, 1'b1, 1'b0, 1'b0);
    drive(1, 1, 1'b1, 1'b1, 1'b0);
    expect_done(10, 1'b0);
    idle(4);

    // Operand forwarding
    drive(5, -3, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("fwd_A_out", $signed(A_out), 5);
    chk("fwd_B_out", $signed(B_out), -3);
    chk("fwd_valid_out", int'(valid_out), 1);
    idle(1);
    chk("fwd_valid_drop", int'(valid_out), 0);
    chk("fwd_A_hold", $signed(A_out), 5);

    // Reset before stage 2 discards the product
    drive(50, 25, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    valid = 1'b0;
    last  = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_y", int'(y), 0);
    chk("midrst_done", int'(done), 0);
    reset = 1'b1;
    idle(3);
    chk("midrst_y_after", int'(y), 0);

    // clear without valid drops accumulated value and pending product
    drive(4, 4, 1'b1, 1'b0, 1'b0);
    drive(50, 25, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("clr_y", int'(y), 0);
    chk("clr_ovf", int'(overflow), 0);
    idle(2);
    chk("clr_y_hold", int'(y), 0);
    drive(2, 3, 1'b1, 1'b1, 1'b0);
    expect_done(6, 1'b0);
    idle(3);

    // clear with valid starts a fresh frame; with last it is a one-element frame
    drive(7, 7, 1'b1, 1'b0, 1'b0);
    drive(3, 4, 1'b1, 1'b1, 1'b1);
    expect_done(12, 1'b0);
    idle(3);
    drive(9, 9, 1'b1, 1'b0, 1'b0);
    drive(2, 5, 1'b1, 1'b0, 1'b1);
    drive(1, 1, 1'b1, 1'b1, 1'b0);
    expect_done(11, 1'b0);
    idle(5);

    chk("sb_empty", sb.size(), 0);
    summary();
    $finish;
  end

endmodule
